// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding unit: shadow-entry layout
// and the forwarding-select width helper used by the EX operand muxes.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } hz_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage view of the instruction being decoded plus the branch flush, as
// seen by the hazard/forwarding unit.
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_regwrite, id_memread, flush
    );

    modport slave (
        input id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input id_rd, id_regwrite, id_memread, flush
    );
endinterface

// File: rtl/hazard_forward_unit_match.sv
// Compares one source register against every shadow entry; reports the
// youngest producer position and whether any load producer is still too young.
module hz_match
    import pipe_pkg::*;
#(
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 2
) (
    input  hz_entry_t                         ent_i [FWD_DEPTH],
    input  logic [REG_AW-1:0]                 rs_i,
    input  logic                              used_i,
    output logic [fwd_sel_w(FWD_DEPTH)-1:0]   sel_o,
    output logic                              load_stall_o
);
    localparam int SEL_W = fwd_sel_w(FWD_DEPTH);

    // Walk oldest to youngest so the youngest match is the one left in sel_o.
    always_comb begin
        sel_o        = '0;
        load_stall_o = 1'b0;
        for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
            if (ent_i[j].valid && ent_i[j].regwrite && used_i &&
                (ent_i[j].rd == rs_i) && (rs_i != '0)) begin
                sel_o = SEL_W'(j + 1);
                if (ent_i[j].memread && ((j + 1) < LOAD_READY)) begin
                    load_stall_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, registered operand-forwarding select and flush unit for the
// 5-stage pipeline; shadows the destination fields of in-flight instructions.
module hazard_forward_unit #(
    parameter int REG_AW     = pipe_pkg::REG_AW,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 32
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    hazard_forward_unit_if.slave                       id_i,
    output logic                                       stall_o,
    output logic                                       pc_write_o,
    output logic                                       ifid_write_o,
    output logic                                       bubble_o,
    output logic [pipe_pkg::fwd_sel_w(FWD_DEPTH)-1:0]  fwd_a_sel_o,
    output logic [pipe_pkg::fwd_sel_w(FWD_DEPTH)-1:0]  fwd_b_sel_o,
    output logic [CNT_W-1:0]                           stall_cnt_o
);
    localparam int SEL_W = pipe_pkg::fwd_sel_w(FWD_DEPTH);

    // Entry rd width comes from pipe_pkg::REG_AW; keep REG_AW at that value.
    pipe_pkg::hz_entry_t ent_q [FWD_DEPTH];
    pipe_pkg::hz_entry_t ent_d [FWD_DEPTH];

    logic [SEL_W-1:0] young_a, young_b;
    logic             ld_a, ld_b;
    logic [SEL_W-1:0] sel_a_d, sel_a_q, sel_b_d, sel_b_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    hz_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_READY(LOAD_READY)) u_match_a (
        .ent_i        (ent_q),
        .rs_i         (id_i.id_rs1),
        .used_i       (id_i.id_rs1_used),
        .sel_o        (young_a),
        .load_stall_o (ld_a)
    );

    hz_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_READY(LOAD_READY)) u_match_b (
        .ent_i        (ent_q),
        .rs_i         (id_i.id_rs2),
        .used_i       (id_i.id_rs2_used),
        .sel_o        (young_b),
        .load_stall_o (ld_b)
    );

    assign stall_o      = id_i.id_valid & ~id_i.flush & (ld_a | ld_b);
    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;
    assign bubble_o     = stall_o | id_i.flush;

    always_comb begin
        ent_d[0] = '0;
        if (id_i.id_valid && !stall_o && !id_i.flush) begin
            ent_d[0].valid    = 1'b1;
            ent_d[0].rd       = id_i.id_rd;
            ent_d[0].regwrite = id_i.id_regwrite;
            ent_d[0].memread  = id_i.id_memread;
        end
        for (int j = 1; j < FWD_DEPTH; j++) begin
            ent_d[j] = ent_q[j-1];
        end

        // A bubble enters EX on stall or flush, so nothing is forwarded to it.
        sel_a_d = bubble_o ? '0 : young_a;
        sel_b_d = bubble_o ? '0 : young_b;

        cnt_d = cnt_q;
        if (stall_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < FWD_DEPTH; j++) begin
                ent_q[j] <= '0;
            end
            sel_a_q <= '0;
            sel_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            for (int j = 0; j < FWD_DEPTH; j++) begin
                ent_q[j] <= ent_d[j];
            end
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a_sel_o = sel_a_q;
    assign fwd_b_sel_o = sel_b_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: three configurations share one ID stream; a history-list
// reference model predicts each cycle's outputs, a negedge monitor compares.
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_AW(5)) ifc ();

    logic       st_w [3];
    logic       pcw_w [3];
    logic       ifw_w [3];
    logic       bub_w [3];
    logic [1:0] sa_w [3];
    logic [1:0] sb_w [3];
    logic [31:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    hazard_forward_unit #(.FWD_DEPTH(2), .LOAD_READY(2), .CNT_W(32)) dut0 (
        .clk_i(clk), .rst_i(rst), .id_i(ifc),
        .stall_o(st_w[0]), .pc_write_o(pcw_w[0]), .ifid_write_o(ifw_w[0]),
        .bubble_o(bub_w[0]), .fwd_a_sel_o(sa_w[0]), .fwd_b_sel_o(sb_w[0]),
        .stall_cnt_o(cnt0)
    );

    hazard_forward_unit #(.FWD_DEPTH(3), .LOAD_READY(3), .CNT_W(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .id_i(ifc),
        .stall_o(st_w[1]), .pc_write_o(pcw_w[1]), .ifid_write_o(ifw_w[1]),
        .bubble_o(bub_w[1]), .fwd_a_sel_o(sa_w[1]), .fwd_b_sel_o(sb_w[1]),
        .stall_cnt_o(cnt1)
    );

    hazard_forward_unit #(.FWD_DEPTH(2), .LOAD_READY(2), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .id_i(ifc),
        .stall_o(st_w[2]), .pc_write_o(pcw_w[2]), .ifid_write_o(ifw_w[2]),
        .bubble_o(bub_w[2]), .fwd_a_sel_o(sa_w[2]), .fwd_b_sel_o(sb_w[2]),
        .stall_cnt_o(cnt2)
    );

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } ment_t;

    typedef struct packed {
        logic        st;
        logic        bub;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [31:0] cnt;
    } exp_t;

    // hist[c][k] = instruction that entered EX k+1 cycles before the ID one.
    int          dep  [3] = '{2, 3, 2};
    int          lr   [3] = '{2, 3, 2};
    logic [31:0] cmax [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    ment_t       hist [3][3];
    int          m_sa [3];
    int          m_sb [3];
    logic [31:0] m_cnt [3];

    exp_t sbq [3][$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] cnt_of(input int c);
        case (c)
            0:       return cnt0;
            1:       return cnt1;
            default: return {30'd0, cnt2};
        endcase
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d t=%0t got %0h expected %0h", name, c, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 3; k++) hist[c][k] = '{0, 0, 0, 0};
            m_sa[c]  = 0;
            m_sb[c]  = 0;
            m_cnt[c] = 0;
        end
    endtask

    // Find the youngest in-flight writer of rs; flag any load writer not yet ready.
    task automatic lookup(input int c, input int rs, input bit used, output int pos, output bit lstall);
        pos    = 0;
        lstall = 0;
        if (used && rs != 0) begin
            for (int k = 0; k < dep[c]; k++) begin
                if (hist[c][k].v && hist[c][k].rw && hist[c][k].rd == rs) begin
                    if (pos == 0) pos = k + 1;
                    if (hist[c][k].mr && (k + 1) < lr[c]) lstall = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int rd, input int rs1, input int rs2,
                        input bit u1, input bit u2, input bit rw, input bit mr, input bit fl);
        @(posedge clk);
        #1;
        rst             = r;
        ifc.id_valid    = v;
        ifc.id_rd       = 5'(rd);
        ifc.id_rs1      = 5'(rs1);
        ifc.id_rs2      = 5'(rs2);
        ifc.id_rs1_used = u1;
        ifc.id_rs2_used = u2;
        ifc.id_regwrite = rw;
        ifc.id_memread  = mr;
        ifc.flush       = fl;
        for (int c = 0; c < 3; c++) begin
            int    pa, pb;
            bit    la, lb, st;
            exp_t  e;
            lookup(c, rs1, u1, pa, la);
            lookup(c, rs2, u2, pb, lb);
            st    = v && !fl && (la || lb);
            e.st  = st;
            e.bub = st || fl;
            e.sa  = 2'(m_sa[c]);
            e.sb  = 2'(m_sb[c]);
            e.cnt = m_cnt[c];
            sbq[c].push_back(e);
            if (r) begin
                for (int k = 0; k < 3; k++) hist[c][k] = '{0, 0, 0, 0};
                m_sa[c]  = 0;
                m_sb[c]  = 0;
                m_cnt[c] = 0;
            end else begin
                for (int k = 2; k > 0; k--) hist[c][k] = hist[c][k-1];
                if (v && !st && !fl) hist[c][0] = '{1, rd, rw, mr};
                else                 hist[c][0] = '{0, 0, 0, 0};
                m_sa[c] = (st || fl) ? 0 : pa;
                m_sb[c] = (st || fl) ? 0 : pb;
                if (st && m_cnt[c] != cmax[c]) m_cnt[c] = m_cnt[c] + 1;
            end
        end
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        step(0, 1, rd, rs1, rs2, 1, 1, 1, 0, 0);
    endtask

    task automatic ld(input int rd, input int rs1);
        step(0, 1, rd, rs1, 0, 1, 0, 1, 1, 0);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (sbq[c].size() > 0) begin
                exp_t e;
                e = sbq[c].pop_front();
                chk("stall", c, {31'd0, st_w[c]}, {31'd0, e.st});
                chk("pc_write", c, {31'd0, pcw_w[c]}, {31'd0, ~e.st});
                chk("ifid_write", c, {31'd0, ifw_w[c]}, {31'd0, ~e.st});
                chk("bubble", c, {31'd0, bub_w[c]}, {31'd0, e.bub});
                chk("fwd_a_sel", c, {30'd0, sa_w[c]}, {30'd0, e.sa});
                chk("fwd_b_sel", c, {30'd0, sb_w[c]}, {30'd0, e.sb});
                chk("stall_cnt", c, cnt_of(c), e.cnt);
            end
        end
    end

    initial begin
        int guard;
        rst             = 1'b1;
        ifc.id_valid    = 1'b0;
        ifc.id_rd       = '0;
        ifc.id_rs1      = '0;
        ifc.id_rs2      = '0;
        ifc.id_rs1_used = 1'b0;
        ifc.id_rs2_used = 1'b0;
        ifc.id_regwrite = 1'b0;
        ifc.id_memread  = 1'b0;
        ifc.flush       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // back-to-back and one-apart ALU forwarding
        alu(5, 1, 2); alu(6, 5, 1); nop(); nop();
        alu(5, 1, 2); alu(9, 3, 4); alu(6, 5, 1); nop(); nop();
        // load-use on rs2 (consumer re-presented while stalled)
        ld(5, 1); alu(6, 1, 5); alu(6, 1, 5); nop(); nop();
        // x0 never matches; youngest of two x7 producers wins
        alu(0, 1, 2); alu(6, 0, 0); nop();
        alu(7, 1, 2); alu(7, 3, 4); alu(8, 7, 1); nop(); nop();
        // load-use coinciding with a flush
        ld(5, 1); step(0, 1, 6, 1, 5, 1, 1, 1, 0, 1); nop(); nop();
        // deeper configuration: two stalls for adjacent, one with a gap
        ld(5, 1); alu(6, 5, 2); alu(6, 5, 2); alu(6, 5, 2); nop(); nop();
        ld(5, 1); nop(); alu(6, 5, 2); alu(6, 5, 2); nop(); nop();
        // repeated stalls drive the narrow counter into saturation
        repeat (5) begin
            ld(5, 1); alu(6, 5, 2); alu(6, 5, 2); alu(6, 5, 2); nop(); nop();
        end
        // reset asserted during a stall cycle
        ld(5, 1); step(1, 1, 6, 5, 2, 1, 1, 1, 0, 0); alu(6, 5, 2); nop(); nop();

        repeat (2000) begin
            bit r, v, mr, fl;
            r  = ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 7) != 0);
            mr = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 7) == 0);
            step(r, v, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), mr, fl);
        end
        nop();

        guard = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        n_chk++;
        if ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the stub hazard detector in the 5-stage RISC-V pipeline: a combined load-use stall, forwarding-select and flush unit.
- Tracks destination registers of in-flight instructions in a shadow shift register that mirrors ID/EX, EX/MEM and MEM/WB.
- Drives the PC write enable, the IF/ID write enable, bubble insertion into ID/EX, and the registered ALU operand-forwarding selects.
- Counts stall cycles for performance measurement.

Parameters:
- REG_AW, 5, register address width (x0 is hard-wired zero and never matches).
- FWD_DEPTH, 2, number of forwarding sources after EX: P1 = EX/MEM, P2 = MEM/WB, … P[FWD_DEPTH].
- LOAD_READY, 2, lowest forwarding position at which load data is valid. Range 2..FWD_DEPTH.
- CNT_W, 32, stall counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i  in  REG_AW  ID source 1 address
- id_rs2_i  in  REG_AW  ID source 2 address
- id_rs1_used_i  in  1  instruction reads rs1
- id_rs2_used_i  in  1  instruction reads rs2
- id_rd_i  in  REG_AW  ID destination
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  taken branch; kill ID and IF
- stall_o  out  1  load-use stall (combinational)
- pc_write_o  out  1  equals ~stall_o
- ifid_write_o  out  1  equals ~stall_o
- bubble_o  out  1  zero control fields entering ID/EX (stall_o | flush_i)
- fwd_a_sel_o  out  clog2(FWD_DEPTH+1)  EX operand A source: 0 = regfile, k = P[k]
- fwd_b_sel_o  out  clog2(FWD_DEPTH+1)  EX operand B source: same encoding
- stall_cnt_o  out  CNT_W  stall cycles since reset, saturating

Behaviour:
- Shadow entries E[0..FWD_DEPTH-1], each holding {valid, rd, regwrite, memread}.
  - E[0] mirrors the instruction now in EX.
  - E[j] will sit at forwarding position P[j+1] when the current ID instruction reaches EX.
- Every cycle, entries shift: E[j+1] <= E[j].
  - E[0] <= ID fields when id_valid_i & ~stall_o & ~flush_i; otherwise E[0] <= bubble (valid = 0).
  - EX never stalls, so the shift is unconditional.
- Match(j, rs) = E[j].valid & E[j].regwrite & (E[j].rd == rs) & (rs != 0) & rs_used.
- stall_o = id_valid_i & ~flush_i & any j with Match(j, rs1 or rs2) & E[j].memread & (j+1 < LOAD_READY).
  - Defaults give exactly one stall cycle for a load followed immediately by a use.
- Forward selects are registered on the edge where ID moves to EX:
  - sel <= j+1 for the smallest matching j (youngest producer wins); 0 if no match.
  - Forced to 0 when stall_o or flush_i, because a bubble enters EX.
- A producer beyond E[FWD_DEPTH-1] is handled by write-first bypass inside the regfile; this block outputs sel = 0 for it.
- flush_i has priority over stall: stall_o = 0, bubble_o = 1, pc_write_o = 1.
- Stall counter: stall_cnt_o increments on each cycle with stall_o = 1 and holds at all-ones.
- Reset (synchronous, active-high): all entries invalid; fwd_a_sel_o = fwd_b_sel_o = 0; stall_cnt_o = 0; hence stall_o = 0 and pc_write_o = ifid_write_o = 1.
  - Reset asserted mid-stall clears the stall on the following cycle.
  - Reset has priority over all other inputs.
- id_valid_i = 0: no stall; the ID contents are treated as a bubble.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef hz_entry_t {valid, rd, regwrite, memread};
  - constant REG_AW;
  - function fwd_sel_w(depth) = clog2(depth+1), so the EX operand muxes size identically.
- One sub-module, hz_match, is natural: combinational compare of one source against all entries, returning a youngest-match index and a load-stall flag. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Producer add x5 then consumer add x6,x5,x1 back-to-back -> no stall; fwd_a_sel_o = 1 in the consumer's EX cycle. Repeat with one independent instruction between them -> fwd_a_sel_o = 2.
- lw x5 followed by add using x5 as rs2 -> stall_o = 1 for exactly one cycle and pc_write_o = 0 during it; then fwd_b_sel_o = 2; stall_cnt_o = 1.
- Consumer reads x0 while the producer writes x0 -> sel = 0, no stall. Two producers of x7 in flight -> sel = 1 (youngest wins).
- lw-use hazard coincident with flush_i = 1 -> stall_o = 0, bubble_o = 1, selects 0 next cycle, counter unchanged.
- FWD_DEPTH = 3, LOAD_READY = 3: lw then use -> two stall cycles, then sel = 3. lw, nop, use -> one stall cycle.
- CNT_W = 2 with five load-use stalls -> stall_cnt_o saturates at 3. rst_i during a stall cycle -> next cycle all outputs at reset values.
